bus_exchange_unit: RTL
======================

BUS_EXCHANGE_UNIT -- requirements
Module: bus_exchange_unit

Interface
REQ-001 Parameter DATA_W, default 32: external and internal data width in bits.
REQ-002 Parameter ADDR_W, default 32: address width in bits.
REQ-003 Parameter PF_DEPTH, default 4: depth of the instruction prefetch queue; power of two, at least 2.
REQ-004 Parameter TIMEOUT_CYC, default 255: number of wait cycles before a bus error is raised.
REQ-005 clk  in  1: single clock; all state changes on the rising edge.
REQ-006 rst  in  1: reset; asynchronous assert, active-low.
REQ-007 flush  in  1: discard the prefetch queue and restart fetching at flush_addr.
REQ-008 flush_addr  in  ADDR_W: new fetch address, sampled when flush=1.
REQ-009 if_pop  in  1: instruction consumer takes the queue head.
REQ-010 if_valid, if_data  out  1, DATA_W: queue not empty; queue head word.
REQ-011 dm_req, dm_we  in  1, 1: data access request; 1=write, 0=read. Both are held until dm_done.
REQ-012 dm_addr, dm_wdata  in  ADDR_W, DATA_W: data access address and write data.
REQ-013 dm_rdata, dm_done  out  DATA_W, 1: read data; single-cycle completion pulse.
REQ-014 ext_addr, ext_wdata  out  ADDR_W, DATA_W: external bus address and write data.
REQ-015 ext_rdata  in  DATA_W: external read data.
REQ-016 ext_strobe, ext_we  out  1, 1: transfer request and transfer direction.
REQ-017 ext_ready  in  1: external exchange ready.
REQ-018 bus_err  out  1: sticky error flag.

Function
REQ-019 The external handshake SHALL be four-phase: strobe rises, ready rises, data is captured, strobe falls, ready falls.
REQ-020 The FSM SHALL have five states: IDLE, REQ, CAPT, REL and ERR.
REQ-021 In IDLE, a pending dm_req SHALL win arbitration over prefetch.
REQ-022 A prefetch SHALL start in IDLE only when the queue holds fewer than PF_DEPTH entries and no fetch is in flight.
REQ-023 IDLE->REQ: the FSM SHALL register ext_addr, ext_we and ext_wdata and assert ext_strobe on the next cycle.
REQ-024 REQ->CAPT: when ext_ready=1, the FSM SHALL latch ext_rdata on a read.
REQ-025 CAPT->REL: the FSM SHALL deassert ext_strobe, push a prefetch word into the queue or pulse dm_done, and advance the fetch address by 4 after a fetch.
REQ-026 REL->IDLE: when ext_ready=0, the FSM SHALL return to IDLE; the minimum transfer is 4 cycles.
REQ-027 ext_addr, ext_we and ext_wdata SHALL stay stable from REQ through REL.
REQ-028 The queue SHALL support a simultaneous push and pop, with the count unchanged.
REQ-029 A pop on an empty queue SHALL be ignored.
REQ-030 A push into a full queue SHALL be impossible by construction.
REQ-031 Read and write pointers SHALL wrap modulo PF_DEPTH.
REQ-032 A flush SHALL empty the queue and load flush_addr in the same cycle.
REQ-033 If a fetch is in flight during a flush, the fetch SHALL complete its handshake and its word SHALL be dropped.
REQ-034 If flush and push occur in the same cycle, the flush SHALL win.
REQ-035 A data access in flight SHALL be unaffected by a flush.
REQ-036 The fetch address SHALL wrap modulo 2^ADDR_W.

Reset
REQ-037 While rst=0, all of the following SHALL hold: state=IDLE; fetch address=0; queue empty; if_valid=0; ext_strobe=0; ext_we=0; ext_addr=0; ext_wdata=0; dm_done=0; dm_rdata=0; bus_err=0.
REQ-038 A reset during a transfer SHALL abort the transfer immediately and drop ext_strobe asynchronously.

Configuration
REQ-039 With macro BUS_EXCHANGE_TIMEOUT_EN defined, the unit SHALL run a wait counter in REQ and in REL.
REQ-040 When that counter reaches TIMEOUT_CYC, the FSM SHALL enter ERR, set bus_err, drop ext_strobe, and pulse dm_done if the transfer was a data access.
REQ-041 ERR SHALL return to IDLE once ext_ready=0.
REQ-042 bus_err SHALL be cleared only by reset.
REQ-043 Without BUS_EXCHANGE_TIMEOUT_EN, the unit SHALL have no counter, the ERR state SHALL be unreachable, bus_err SHALL be tied to 0, and the unit SHALL wait indefinitely.

Structure
REQ-044 Package bus_exchange_pkg SHALL hold the FSM state enum, the fetch address increment constant (4) and the reset address constant (0).
REQ-045 The prefetch queue SHALL be a sub-module named prefetch_fifo, parametrised by DATA_W and PF_DEPTH, with push, pop, flush, empty, full and count.

Verification
REQ-046 Reset, then release rst; ext_ready answers each strobe 1 cycle later and holds high 3 cycles -> fetches from addresses 0, 4, 8, 12; the queue fills to 4; ext_strobe stays 0 while full.
REQ-047 Queue holds 1281 at address 0 and 114691 at address 4; pop twice -> if_data shows 1281 then 114691; if_valid falls after the second pop when no fetch is pending.
REQ-048 dm_req=1, dm_we=0, dm_addr=0x100 issued together with a pending prefetch -> ext_addr=0x100 first; dm_done pulses once; dm_rdata equals ext_rdata.
REQ-049 Flush with flush_addr=0x40 during a fetch of address 8 -> that word is discarded; the next ext_addr is 0x40; the queue is empty after the flush.
REQ-050 With BUS_EXCHANGE_TIMEOUT_EN and TIMEOUT_CYC=8, hold ext_ready=0 -> bus_err=1 after 8 cycles in REQ and ext_strobe=0; bus_err stays 1 until rst=0.
REQ-051 Drive rst=0 mid-handshake while in CAPT -> ext_strobe drops without waiting for a clock edge; after release, fetching restarts at address 0.

Source files
------------

// File: rtl/bus_exchange_pkg.sv
// Shared types and constants for the bus exchange unit and its prefetch queue.
package bus_exchange_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_CAPT = 3'd2,
    ST_REL  = 3'd3,
    ST_ERR  = 3'd4
  } bxu_state_e;

  localparam int unsigned FETCH_INC  = 4;
  localparam int unsigned RESET_ADDR = 0;

endpackage

// File: rtl/prefetch_fifo.sv
// Instruction prefetch queue: circular buffer with count, flush has priority over push/pop.
module prefetch_fifo
  import bus_exchange_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned PF_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           flush,
  input  logic [DATA_W-1:0]              wdata,
  output logic [DATA_W-1:0]              rdata,
  output logic                           empty,
  output logic                           full,
  output logic [$clog2(PF_DEPTH+1)-1:0]  count
);

  localparam int unsigned PTR_W = $clog2(PF_DEPTH);
  localparam int unsigned CNT_W = $clog2(PF_DEPTH + 1);

  logic [DATA_W-1:0] r_mem [PF_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CNT_W'(PF_DEPTH));
  assign count     = r_count;
  assign rdata     = r_mem[r_rd_ptr];
  assign w_do_push = push && !full && !flush;
  assign w_do_pop  = pop && !empty && !flush;

  // Pointers wrap naturally because PF_DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wdata;
  end

endmodule

// File: rtl/bus_exchange_unit.sv
// Four-phase external bus master arbitrating data accesses over instruction prefetch.
// Optional wait-cycle watchdog enabled by defining BUS_EXCHANGE_TIMEOUT_EN.
module bus_exchange_unit
  import bus_exchange_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned PF_DEPTH    = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_addr,
  input  logic              if_pop,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_data,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic [ADDR_W-1:0] ext_addr,
  output logic [DATA_W-1:0] ext_wdata,
  input  logic [DATA_W-1:0] ext_rdata,
  output logic              ext_strobe,
  output logic              ext_we,
  input  logic              ext_ready,
  output logic              bus_err
);

  localparam int unsigned CNT_W = $clog2(PF_DEPTH + 1);

  bxu_state_e        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_fetch_addr, w_fetch_addr_nxt;
  logic [ADDR_W-1:0] r_ext_addr, w_ext_addr_nxt;
  logic [DATA_W-1:0] r_ext_wdata, w_ext_wdata_nxt;
  logic [DATA_W-1:0] r_cap, w_cap_nxt;
  logic [DATA_W-1:0] r_dm_rdata, w_dm_rdata_nxt;
  logic              r_ext_we, w_ext_we_nxt;
  logic              r_ext_strobe, w_ext_strobe_nxt;
  logic              r_dm_done, w_dm_done_nxt;
  logic              r_is_fetch, w_is_fetch_nxt;
  logic              r_drop, w_drop_nxt;
  logic              w_push;
  logic              w_empty;
  logic              w_full;
  logic              w_room;
  logic [CNT_W-1:0]  w_count;

`ifdef BUS_EXCHANGE_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYC + 1);
  logic [WAIT_W-1:0] r_wait, w_wait_nxt;
  logic              r_bus_err, w_bus_err_nxt;
  assign bus_err = r_bus_err;
`else
  // No watchdog: the handshake waits on ext_ready indefinitely.
  if (TIMEOUT_CYC == 0) begin : g_no_watchdog
  end
  assign bus_err = 1'b0;
`endif

  prefetch_fifo #(
    .DATA_W   (DATA_W),
    .PF_DEPTH (PF_DEPTH)
  ) u_pf_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (if_pop),
    .flush (flush),
    .wdata (r_cap),
    .rdata (if_data),
    .empty (w_empty),
    .full  (w_full),
    .count (w_count)
  );

  assign w_room     = (w_count < CNT_W'(PF_DEPTH));
  assign if_valid   = !w_empty;
  assign ext_addr   = r_ext_addr;
  assign ext_wdata  = r_ext_wdata;
  assign ext_we     = r_ext_we;
  assign ext_strobe = r_ext_strobe;
  assign dm_done    = r_dm_done;
  assign dm_rdata   = r_dm_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_fetch_addr <= ADDR_W'(RESET_ADDR);
      r_ext_addr   <= '0;
      r_ext_wdata  <= '0;
      r_ext_we     <= 1'b0;
      r_ext_strobe <= 1'b0;
      r_cap        <= '0;
      r_dm_rdata   <= '0;
      r_dm_done    <= 1'b0;
      r_is_fetch   <= 1'b0;
      r_drop       <= 1'b0;
`ifdef BUS_EXCHANGE_TIMEOUT_EN
      r_wait       <= '0;
      r_bus_err    <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_fetch_addr <= w_fetch_addr_nxt;
      r_ext_addr   <= w_ext_addr_nxt;
      r_ext_wdata  <= w_ext_wdata_nxt;
      r_ext_we     <= w_ext_we_nxt;
      r_ext_strobe <= w_ext_strobe_nxt;
      r_cap        <= w_cap_nxt;
      r_dm_rdata   <= w_dm_rdata_nxt;
      r_dm_done    <= w_dm_done_nxt;
      r_is_fetch   <= w_is_fetch_nxt;
      r_drop       <= w_drop_nxt;
`ifdef BUS_EXCHANGE_TIMEOUT_EN
      r_wait       <= w_wait_nxt;
      r_bus_err    <= w_bus_err_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_fetch_addr_nxt = r_fetch_addr;
    w_ext_addr_nxt   = r_ext_addr;
    w_ext_wdata_nxt  = r_ext_wdata;
    w_ext_we_nxt     = r_ext_we;
    w_ext_strobe_nxt = r_ext_strobe;
    w_cap_nxt        = r_cap;
    w_dm_rdata_nxt   = r_dm_rdata;
    w_dm_done_nxt    = 1'b0;
    w_is_fetch_nxt   = r_is_fetch;
    w_drop_nxt       = r_drop;
    w_push           = 1'b0;
`ifdef BUS_EXCHANGE_TIMEOUT_EN
    w_wait_nxt       = r_wait;
    w_bus_err_nxt    = r_bus_err;
`endif

    case (r_state)
      ST_IDLE: begin
`ifdef BUS_EXCHANGE_TIMEOUT_EN
        w_wait_nxt = '0;
`endif
        if (dm_req) begin
          w_ext_addr_nxt   = dm_addr;
          w_ext_we_nxt     = dm_we;
          w_ext_wdata_nxt  = dm_wdata;
          w_ext_strobe_nxt = 1'b1;
          w_is_fetch_nxt   = 1'b0;
          w_drop_nxt       = 1'b0;
          w_state_nxt      = ST_REQ;
        end else if (w_room && !flush) begin
          // A flush in this cycle would retarget the fetch, so defer it one cycle.
          w_ext_addr_nxt   = r_fetch_addr;
          w_ext_we_nxt     = 1'b0;
          w_ext_wdata_nxt  = '0;
          w_ext_strobe_nxt = 1'b1;
          w_is_fetch_nxt   = 1'b1;
          w_drop_nxt       = 1'b0;
          w_state_nxt      = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ext_ready) begin
          if (!r_ext_we) w_cap_nxt = ext_rdata;
          w_state_nxt = ST_CAPT;
        end
`ifdef BUS_EXCHANGE_TIMEOUT_EN
        else if (r_wait == WAIT_W'(TIMEOUT_CYC - 1)) begin
          w_state_nxt      = ST_ERR;
          w_ext_strobe_nxt = 1'b0;
          w_bus_err_nxt    = 1'b1;
          w_dm_done_nxt    = !r_is_fetch;
        end else begin
          w_wait_nxt = r_wait + WAIT_W'(1);
        end
`endif
      end
      ST_CAPT: begin
        w_ext_strobe_nxt = 1'b0;
        w_state_nxt      = ST_REL;
`ifdef BUS_EXCHANGE_TIMEOUT_EN
        w_wait_nxt       = '0;
`endif
        if (r_is_fetch) begin
          if (!r_drop && !flush) begin
            w_push           = !w_full;
            w_fetch_addr_nxt = r_fetch_addr + ADDR_W'(FETCH_INC);
          end
        end else begin
          w_dm_done_nxt = 1'b1;
          if (!r_ext_we) w_dm_rdata_nxt = r_cap;
        end
      end
      ST_REL: begin
        if (!ext_ready) w_state_nxt = ST_IDLE;
`ifdef BUS_EXCHANGE_TIMEOUT_EN
        else if (r_wait == WAIT_W'(TIMEOUT_CYC - 1)) begin
          w_state_nxt   = ST_ERR;
          w_bus_err_nxt = 1'b1;
        end else begin
          w_wait_nxt = r_wait + WAIT_W'(1);
        end
`endif
      end
      ST_ERR: begin
        if (!ext_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Flush retargets fetching; a fetch already on the bus finishes but its word is dropped.
    if (flush) begin
      w_fetch_addr_nxt = flush_addr;
      if ((r_state != ST_IDLE) && r_is_fetch) w_drop_nxt = 1'b1;
    end
  end

endmodule
